// File: rtl/dcache_flush_ctrl.sv
// dcache_flush_ctrl: core-side sequencer for the data-cache management port.
//   Drives cache enable/flush, runs drain -> flush -> done for fence requests
//   and for cache disable, and keeps a saturating miss counter plus a sticky
//   flush watchdog for the CSR file.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   flush_req_i                : level flush request, held until flush_done_o
//   enable_i                   : CSR cache-enable value (acted on only in IDLE)
//   miss_clr_i                 : synchronous clear of miss_cnt_o
//   dcache_enable_o/_flush_o   : controls into the cache
//   dcache_flush_ack_i         : flush-complete pulse from the cache
//   dcache_miss_i              : cache miss this cycle
//   wbuffer_empty_i            : cache write path drained
//   flush_done_o, busy_o       : requester handshake / FSM activity
//   timeout_err_o, miss_cnt_o  : CSR-visible status
module dcache_flush_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MISS_CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req_i,
  input  logic                  enable_i,
  input  logic                  miss_clr_i,
  output logic                  dcache_enable_o,
  output logic                  dcache_flush_o,
  input  logic                  dcache_flush_ack_i,
  input  logic                  dcache_miss_i,
  input  logic                  wbuffer_empty_i,
  output logic                  flush_done_o,
  output logic                  busy_o,
  output logic                  timeout_err_o,
  output logic [MISS_CNT_W-1:0] miss_cnt_o
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // origin: 0 = flush requested by flush_req_i, 1 = flush caused by disable
  logic [1:0]            state_q, state_d;
  logic                  origin_q, origin_d;
  logic                  enable_q, enable_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  err_q, err_d;
  logic [MISS_CNT_W-1:0] miss_q, miss_d;

  always_comb begin
    state_d  = state_q;
    origin_d = origin_q;
    enable_d = enable_q;
    wd_d     = wd_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        // A pending request beats a pending disable; the disable is
        // picked up again once the request's flush returns to IDLE.
        if (flush_req_i) begin
          state_d  = S_DRAIN;
          origin_d = 1'b0;
          wd_d     = '0;
        end else if (!enable_i && enable_q) begin
          state_d  = S_DRAIN;
          origin_d = 1'b1;
          wd_d     = '0;
        end else if (enable_i && !enable_q) begin
          enable_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
        if (wbuffer_empty_i) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
        if (dcache_flush_ack_i) begin
          state_d = S_DONE;
          // A disable-triggered flush drops the enable on the ack edge so the
          // cache is never enabled with stale contents afterwards.
          if (origin_q) enable_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The watchdog only reaches its limit while waiting, so this sets the
    // sticky error exactly when the wait hits TIMEOUT_CYCLES.
    if (wd_d == WD_MAX) err_d = 1'b1;
  end

  always_comb begin
    miss_d = miss_q;
    if (miss_clr_i) begin
      miss_d = '0;
    end else if (dcache_miss_i && (miss_q != {MISS_CNT_W{1'b1}})) begin
      miss_d = miss_q + MISS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      origin_q <= 1'b0;
      enable_q <= 1'b0;
      wd_q     <= '0;
      err_q    <= 1'b0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      origin_q <= origin_d;
      enable_q <= enable_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      miss_q   <= miss_d;
    end
  end

  // Flush/done/busy are decoded from state so an asynchronous reset removes
  // the flush request within the same cycle.
  assign dcache_enable_o = enable_q;
  assign dcache_flush_o  = (state_q == S_FLUSH);
  assign flush_done_o    = (state_q == S_DONE) && !origin_q;
  assign busy_o          = (state_q != S_IDLE);
  assign timeout_err_o   = err_q;
  assign miss_cnt_o      = miss_q;

endmodule
